// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial pin front-end blocks.
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop 1-bit synchroniser for an asynchronous pin input.
// RST_VAL lets a pin sit at its inactive level while in reset.
module pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
        end
    end

    assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/serial_word_deser.sv
// Deserialises a 3-wire pin stream (clock, data, frame) into WIDTH-bit words,
// MSB first, delivered through a single-entry valid/ready output buffer.
module serial_word_deser
    import serial_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_clk,
    input  logic             ser_data,
    input  logic             ser_frame_n,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_sync;
    logic data_sync;
    logic frame_n_sync;

    // All three pins share the same depth so data and frame stay aligned
    // with the synchronised bit clock.
    pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ser_clk),
        .dout  (sclk_sync)
    );

    pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ser_data),
        .dout  (data_sync)
    );

    pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ser_frame_n),
        .dout  (frame_n_sync)
    );

    logic             sclk_prev_reg;
    logic             sclk_rise;
    state_t           state_reg;
    logic [WIDTH-2:0] shreg_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             overrun_reg;
    logic             frame_err_reg;
    logic [WIDTH-1:0] word_next;
    logic             word_done;

    assign sclk_rise = sclk_sync & ~sclk_prev_reg;
    assign word_next = {shreg_reg, data_sync};
    assign word_done = (state_reg == ST_SHIFT) && sclk_rise && (count_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_reg <= 1'b0;
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            count_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_sync;
            frame_err_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    count_reg <= '0;
                    if (!frame_n_sync) begin
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        shreg_reg <= word_next[WIDTH-2:0];
                        count_reg <= word_done ? '0 : count_reg + 1'b1;
                    end
                    // A word completing on the closing cycle is still kept.
                    if (frame_n_sync) begin
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                        if ((count_reg != '0) && !word_done) begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (word_done) begin
                if (!out_valid_reg || out_ready) begin
                    out_data_reg  <= word_next;
                    out_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule
